// File: rtl/sbox_share_arb.sv
// sbox_share_arb: shares NSB AES S-box lanes between SubBytes (D) and SubWord (K) requesters.
// Define SBOX_ARB_RR_EN for round-robin arbitration instead of fixed K-over-D priority.
module sbox_share_arb #(
  parameter int NSB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d_req,
  input  logic [127:0] d_in,
  output logic         d_ack,
  output logic [127:0] d_out,
  input  logic         k_req,
  input  logic [31:0]  k_in,
  output logic         k_ack,
  output logic [31:0]  k_out,
  output logic         busy
);
  localparam int NB = 16 / NSB;
  typedef enum logic [2:0] {IDLE, DATA, KEY, DACK, KACK} state_t;
  state_t state, state_n;
  logic [1:0] beat;
  logic [127:0] d_reg;
  logic [31:0] k_reg;
  logic [NSB-1:0][7:0] lane_in, lane_out;
  logic k_win, last;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // GF(2^8) inverse as x^254 (0 maps to 0), then the FIPS-197 affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, b;
    sq = x;
    b = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      b = gmul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
`ifdef SBOX_ARB_RR_EN
  logic last_k;
  assign k_win = k_req & (~d_req | ~last_k);
  always_ff @(posedge clk)
    if (rst) last_k <= 1'b0;
    else if (state == IDLE && (k_req || d_req)) last_k <= k_win;
`else
  assign k_win = k_req;
`endif
  assign last = beat == 2'(NB - 1);
  assign d_ack = state == DACK;
  assign k_ack = state == KACK;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE ? (k_win ? KEY : d_req ? DATA : IDLE) :
              state == DATA ? (last ? DACK : DATA) :
              state == KEY  ? KACK : IDLE;
    lane_in = state == KEY ? (NSB*8)'(k_reg) : d_reg[int'(beat)*NSB*8 +: NSB*8];
    for (int l = 0; l < NSB; l++) lane_out[l] = sbox(lane_in[l]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      beat <= 2'd0;
      d_reg <= '0;
      k_reg <= '0;
      d_out <= '0;
      k_out <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && k_win) k_reg <= k_in;
      if (state == IDLE && !k_win && d_req) begin
        d_reg <= d_in;
        beat <= 2'd0;
      end
      if (state == DATA) begin
        d_out[int'(beat)*NSB*8 +: NSB*8] <= lane_out;
        beat <= beat + 2'd1;
      end
      if (state == KEY) k_out <= lane_out[3:0];
    end
endmodule
